// File: rtl/tx_sched_pkg.sv
// Shared constants and types for the transmit frame scheduler and its arbiter.
package tx_sched_pkg;

    localparam int WORD_W = 16;
    localparam int MAX_N  = 8;
    localparam int IDX_W  = $clog2(MAX_N);

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] SEND_ENC = 2'd1;
    localparam logic [1:0] GAP_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE_ENC,
        ST_SEND = SEND_ENC,
        ST_GAP  = GAP_ENC
    } sched_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_rr_pick.sv
// Combinational requester picker: round-robin from rr_ptr, or lowest-index-wins
// when TX_FIXED_PRIO_EN is defined.
module rr_pick
    import tx_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

`ifdef TX_FIXED_PRIO_EN
    logic unused_rr_ptr_s;
    assign unused_rr_ptr_s = ^rr_ptr;

    // Lowest requesting index wins; scanning downward lets the lowest overwrite last.
    always_comb begin
        valid  = |req;
        winner = {IDX_W{1'b0}};
        for (int j = N - 1; j >= 0; j--) begin
            winner = req[j] ? IDX_W'(j) : winner;
        end
    end
`else
    // Winner is the requester at the smallest circular distance from rr_ptr.
    always_comb begin
        int best_d;
        int d;
        valid  = |req;
        winner = {IDX_W{1'b0}};
        best_d = N;
        for (int j = 0; j < N; j++) begin
            d = j - int'(rr_ptr);
            d = (d < 0) ? d + N : d;
            winner = (req[j] && (d < best_d)) ? IDX_W'(j) : winner;
            best_d = (req[j] && (d < best_d)) ? d : best_d;
        end
    end
`endif

endmodule

// File: rtl/tx_frame_scheduler.sv
// Shares one serial transmitter among N requesters: arbitrate, hold tx_start for a
// fixed frame window, then force an idle gap. Optional macro: TX_FIXED_PRIO_EN.
module tx_frame_scheduler
    import tx_sched_pkg::*;
#(
    parameter int N            = 4,
    parameter int FRAME_CYCLES = 24,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                clk_115200hz,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [WORD_W*N-1:0] req_data,
    output logic [N-1:0]        grant_ack,
    output logic                tx_start,
    output logic [WORD_W-1:0]   tx_data,
    output logic                busy,
    output logic [IDX_W-1:0]    grant_id
);

    localparam int CNT_W = $clog2(max2(FRAME_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : CNT_ZERO;

    sched_state_t      state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0]  rr_ptr_r, rr_ptr_nxt_s;
    logic [N-1:0]      grant_ack_r, grant_ack_nxt_s;
    logic              tx_start_r, tx_start_nxt_s;
    logic [WORD_W-1:0] tx_data_r, tx_data_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic [IDX_W-1:0]  grant_id_r, grant_id_nxt_s;

    logic              valid_s;
    logic [IDX_W-1:0]  winner_s;
    logic [WORD_W-1:0] word_s;
    logic [IDX_W-1:0]  ptr_after_s;

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_r),
        .valid  (valid_s),
        .winner (winner_s)
    );

    // Select the winning requester's word slice.
    always_comb begin
        word_s = {WORD_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            word_s = (winner_s == IDX_W'(i)) ? req_data[WORD_W*i +: WORD_W] : word_s;
        end
    end

    // Round-robin pointer after a grant; tied to zero in fixed-priority builds.
`ifdef TX_FIXED_PRIO_EN
    assign ptr_after_s = {IDX_W{1'b0}};
`else
    assign ptr_after_s = (winner_s == IDX_W'(N - 1)) ? {IDX_W{1'b0}} : (winner_s + {{(IDX_W-1){1'b0}}, 1'b1});
`endif

    // Next-state and next-output logic for IDLE -> SEND -> GAP -> IDLE.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        grant_ack_nxt_s = {N{1'b0}};
        tx_start_nxt_s  = tx_start_r;
        tx_data_nxt_s   = tx_data_r;
        busy_nxt_s      = busy_r;
        grant_id_nxt_s  = grant_id_r;

        case (state_r)
            ST_IDLE: begin
                if (valid_s) begin
                    state_nxt_s     = ST_SEND;
                    cnt_nxt_s       = FRAME_LOAD;
                    rr_ptr_nxt_s    = ptr_after_s;
                    grant_ack_nxt_s = {{(N-1){1'b0}}, 1'b1} << winner_s;
                    tx_start_nxt_s  = 1'b1;
                    tx_data_nxt_s   = word_s;
                    busy_nxt_s      = 1'b1;
                    grant_id_nxt_s  = winner_s;
                end else begin
                    tx_start_nxt_s  = 1'b0;
                    busy_nxt_s      = 1'b0;
                end
            end
            ST_SEND: begin
                if (cnt_r == CNT_ZERO) begin
                    tx_start_nxt_s = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        state_nxt_s = ST_GAP;
                        cnt_nxt_s   = GAP_LOAD;
                        busy_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                        busy_nxt_s  = 1'b0;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_GAP: begin
                tx_start_nxt_s = 1'b0;
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                end else begin
                    cnt_nxt_s  = cnt_r - CNT_ONE;
                    busy_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                cnt_nxt_s      = CNT_ZERO;
                tx_start_nxt_s = 1'b0;
                busy_nxt_s     = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset clears outputs even mid-frame.
    always_ff @(posedge clk_115200hz or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            rr_ptr_r    <= {IDX_W{1'b0}};
            grant_ack_r <= {N{1'b0}};
            tx_start_r  <= 1'b0;
            tx_data_r   <= {WORD_W{1'b0}};
            busy_r      <= 1'b0;
            grant_id_r  <= {IDX_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            grant_ack_r <= grant_ack_nxt_s;
            tx_start_r  <= tx_start_nxt_s;
            tx_data_r   <= tx_data_nxt_s;
            busy_r      <= busy_nxt_s;
            grant_id_r  <= grant_id_nxt_s;
        end
    end

    assign grant_ack = grant_ack_r;
    assign tx_start  = tx_start_r;
    assign tx_data   = tx_data_r;
    assign busy      = busy_r;
    assign grant_id  = grant_id_r;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler: default instance (GAP=2) plus a GAP=0 instance.
module tb_tx_frame_scheduler;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_a, req_b;
    logic [16*N-1:0] data_a, data_b;
    logic [N-1:0]    ack_a, ack_b;
    logic            start_a, start_b, busy_a, busy_b;
    logic [15:0]     txd_a, txd_b;
    logic [2:0]      gid_a, gid_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tx_frame_scheduler #(.N(N), .FRAME_CYCLES(24), .GAP_CYCLES(2)) dut_a (
        .clk_115200hz (clk), .reset (reset), .req (req_a), .req_data (data_a),
        .grant_ack (ack_a), .tx_start (start_a), .tx_data (txd_a), .busy (busy_a), .grant_id (gid_a)
    );

    tx_frame_scheduler #(.N(N), .FRAME_CYCLES(24), .GAP_CYCLES(0)) dut_b (
        .clk_115200hz (clk), .reset (reset), .req (req_b), .req_data (data_b),
        .grant_ack (ack_b), .tx_start (start_b), .tx_data (txd_b), .busy (busy_b), .grant_id (gid_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack_a(output int cyc);
        cyc = 0;
        while (ack_a == '0 && cyc < 300) begin
            step(1);
            cyc++;
        end
        check("ack_a_timeout", 32'(ack_a != '0), 32'd1);
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (busy_a && n < 300) begin
            step(1);
            n++;
        end
        check("idle_a_timeout", 32'(busy_a), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, hi, lo, acks, bad, exp_id;
        logic [15:0] exp_w;
        reset  = 1'b0;
        req_a  = '0;
        req_b  = '0;
        data_a = '0;
        data_b = '0;
        step(3);

        // Reset state
        check("rst_start", 32'(start_a), 32'd0);
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_ack",   32'(ack_a),   32'd0);
        check("rst_txd",   32'(txd_a),   32'd0);
        check("rst_gid",   32'(gid_a),   32'd0);
        reset = 1'b1;

        // 1) No requests: nothing happens for 50 cycles
        for (int i = 0; i < 50; i++) begin
            step(1);
            check("idle_quiet", 32'({start_a, busy_a, ack_a}), 32'd0);
        end

        // 2) Single request, full frame timing
        data_a[32 +: 16] = 16'hA55A;
        req_a = 4'b0100;
        step(1);
        check("t2_ack",   32'(ack_a),   32'h4);
        check("t2_txd",   32'(txd_a),   32'hA55A);
        check("t2_start", 32'(start_a), 32'd1);
        check("t2_busy",  32'(busy_a),  32'd1);
        check("t2_gid",   32'(gid_a),   32'd2);
        req_a = '0;
        hi = 1; acks = 1; bad = 0;
        step(1);
        while (start_a === 1'b1 && hi < 100) begin
            hi++;
            if (ack_a != '0) acks++;
            if (txd_a !== 16'hA55A) bad++;
            step(1);
        end
        check("t2_high_cycles", 32'(hi),   32'd24);
        check("t2_ack_pulses",  32'(acks), 32'd1);
        check("t2_txd_stable",  32'(bad),  32'd0);
        lo = 0; bad = 0;
        while (busy_a === 1'b1 && lo < 100) begin
            lo++;
            if (start_a) bad++;
            step(1);
        end
        check("t2_gap_cycles", 32'(lo),  32'd2);
        check("t2_gap_low",    32'(bad), 32'd0);
        check("t2_end_busy",   32'(busy_a), 32'd0);

        // 3) All requesting: grant order and frame spacing
        do_reset();
        data_a = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        req_a  = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_ack_a(cyc);
`ifdef TX_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = g % 4;
`endif
            exp_w = 16'hD000 + 16'(exp_id);
            check("t3_gid", 32'(gid_a), 32'(exp_id));
            check("t3_txd", 32'(txd_a), 32'(exp_w));
            check("t3_ack", 32'(ack_a), 32'(1 << exp_id));
            if (g == 0) check("t3_latency", 32'(cyc), 32'd1);
            else        check("t3_spacing", 32'(cyc + 1), 32'd27);
            step(1);
        end
        req_a = '0;
        wait_idle_a();

        // 4) Inputs changing during SEND are ignored
        do_reset();
        data_a = {16'h3333, 16'h0000, 16'h1111, 16'h0000};
        req_a  = 4'b0010;
        wait_ack_a(cyc);
        check("t4_gid1", 32'(gid_a), 32'd1);
        req_a = '0;
        step(5);
        data_a[16 +: 16] = 16'hBEEF;
        req_a = 4'b1000;
        step(1);
        check("t4_txd_frozen", 32'(txd_a), 32'h1111);
        check("t4_no_ack",     32'(ack_a), 32'd0);
        wait_ack_a(cyc);
        check("t4_after_gap", 32'(6 + cyc), 32'd27);
        check("t4_gid3",      32'(gid_a), 32'd3);
        check("t4_txd3",      32'(txd_a), 32'h3333);
        req_a = '0;
        wait_idle_a();

        // 5) Async reset mid-frame; pending request re-arbitrated from pointer 0
        data_a = {16'h7777, 16'h5A5A, 16'h0000, 16'h0000};
        req_a  = 4'b0100;
        wait_ack_a(cyc);
        req_a = 4'b1100;
        step(10);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_start", 32'(start_a), 32'd0);
        check("t5_async_busy",  32'(busy_a),  32'd0);
        check("t5_async_txd",   32'(txd_a),   32'd0);
        step(1);
        reset = 1'b1;
        step(1);
        check("t5_ack", 32'(ack_a),   32'h4);
        check("t5_gid", 32'(gid_a),   32'd2);
        check("t5_txd", 32'(txd_a),   32'h5A5A);
        check("t5_start", 32'(start_a), 32'd1);
        req_a = '0;
        wait_idle_a();

        // 6) GAP_CYCLES=0: back-to-back frames with a single idle cycle
        data_b[16 +: 16] = 16'hBBBB;
        req_b = 4'b0010;
        cyc = 0;
        while (ack_b == '0 && cyc < 300) begin
            step(1);
            cyc++;
        end
        check("t6_first_ack", 32'(ack_b), 32'h2);
        check("t6_txd",       32'(txd_b), 32'hBBBB);
        hi = 0;
        while (start_b === 1'b1 && hi < 100) begin
            hi++;
            step(1);
        end
        check("t6_high_cycles", 32'(hi), 32'd24);
        lo = 0; bad = 0;
        while (start_b === 1'b0 && lo < 100) begin
            lo++;
            if (busy_b) bad++;
            step(1);
        end
        check("t6_low_cycles", 32'(lo),  32'd1);
        check("t6_low_idle",   32'(bad), 32'd0);
        check("t6_second_ack", 32'(ack_b), 32'h2);
        check("t6_gid",        32'(gid_b), 32'd1);
        req_b = '0;
        step(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
